// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 channel mux: steps the select through the enabled channels,
// dwells, captures f_in and offers it on a valid/ready port. `SCAN_CONT_EN enables wrap-around scanning.
module mux_scan_ctrl #(
    parameter int DW    = 3,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [3:0]    chan_mask,
    input  logic [DW-1:0] f_in,
    output logic [1:0]    s,
    output logic          busy,
    output logic          smp_valid,
    input  logic          smp_ready,
    output logic [DW-1:0] smp_data,
    output logic [1:0]    smp_ch,
    output logic          done
);
    localparam int CW = $clog2(DWELL) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    mask_q, mask_n;
    logic [1:0]    s_n, smp_ch_n;
    logic [DW-1:0] smp_data_n;
    logic          smp_valid_n, done_n;
    logic [2:0]    nxt;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest = 2'(i);
    endfunction

    // {found, channel}: nearest enabled channel strictly above c
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] c);
        next_above = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (m[i] && (i > int'(c))) next_above = {1'b1, 2'(i)};
    endfunction

    assign busy = (state != IDLE);
    assign nxt  = next_above(mask_q, s);

    always_comb begin
        state_n     = state;
        s_n         = s;
        cnt_n       = cnt;
        mask_n      = mask_q;
        smp_valid_n = smp_valid;
        smp_data_n  = smp_data;
        smp_ch_n    = smp_ch;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start && (chan_mask != 4'd0)) begin
                    mask_n  = chan_mask;
                    s_n     = lowest(chan_mask);
                    cnt_n   = CNT_INIT;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    smp_valid_n = 1'b0;
                    state_n     = IDLE;
                end else if (cnt == '0) begin
                    smp_data_n  = f_in;
                    smp_ch_n    = s;
                    smp_valid_n = 1'b1;
                    state_n     = HOLD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            HOLD: begin
                // stop wins over advancing; a coincident handshake just retires the sample
                if (stop) begin
                    smp_valid_n = 1'b0;
                    state_n     = IDLE;
                end else if (smp_valid && smp_ready) begin
                    smp_valid_n = 1'b0;
                    if (nxt[2]) begin
                        s_n     = nxt[1:0];
                        cnt_n   = CNT_INIT;
                        state_n = SETTLE;
                    end else begin
                        done_n = 1'b1;
`ifdef SCAN_CONT_EN
                        s_n     = lowest(mask_q);
                        cnt_n   = CNT_INIT;
                        state_n = SETTLE;
`else
                        state_n = IDLE;
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= 2'd0;
            cnt       <= '0;
            mask_q    <= 4'd0;
            smp_valid <= 1'b0;
            smp_data  <= '0;
            smp_ch    <= 2'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            cnt       <= cnt_n;
            mask_q    <= mask_n;
            smp_valid <= smp_valid_n;
            smp_data  <= smp_data_n;
            smp_ch    <= smp_ch_n;
            done      <= done_n;
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized scoreboard bench for mux_scan_ctrl: expected samples come from the enabled-channel list,
// a negedge monitor pops and compares on every handshake.
module tb_mux_scan_ctrl;
    localparam int DW    = 3;
    localparam int DWELL = 4;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, smp_ready = 1'b0;
    logic [3:0]    chan_mask = 4'd0;
    logic [DW-1:0] f_in, smp_data;
    logic [1:0]    s, smp_ch;
    logic          busy, smp_valid, done;
    logic [DW-1:0] w [4];

    assign f_in = w[s];
    always #5 clk = ~clk;

    mux_scan_ctrl #(.DW(DW), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chan_mask(chan_mask),
        .f_in(f_in), .s(s), .busy(busy), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_data(smp_data), .smp_ch(smp_ch), .done(done)
    );

    int            n_cmp = 0, n_bad = 0, done_seen = 0;
    logic [DW+1:0] exp_q [$];
    logic [3:0]    cur_mask = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: scoreboard pops, hold stability, select legality, done width
    logic          p_hold = 1'b0, p_done = 1'b0;
    logic [1:0]    p_s = 2'd0, p_ch = 2'd0;
    logic [DW-1:0] p_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (p_hold) begin
                check("hold_valid", 32'(smp_valid), 32'd1);
                check("hold_data", 32'(smp_data), 32'(p_data));
                check("hold_ch", 32'(smp_ch), 32'(p_ch));
                check("hold_s", 32'(s), 32'(p_s));
            end
            if (smp_valid && smp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sample: got ch%0d data %0h expected no sample", smp_ch, smp_data);
                end else begin
                    check("sample", 32'({smp_ch, smp_data}), 32'(exp_q.pop_front()));
                end
            end
            if (busy) check("s_enabled", 32'(cur_mask[s]), 32'd1);
            if (done) begin
                done_seen <= done_seen + 1;
                check("done_one_cycle", 32'(p_done), 32'd0);
            end
            p_hold <= smp_valid && !smp_ready && !stop;
            p_done <= done;
        end else begin
            p_hold <= 1'b0;
            p_done <= 1'b0;
        end
        p_s    <= s;
        p_ch   <= smp_ch;
        p_data <= smp_data;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [3:0] m);
        chan_mask = m;
        if (m != 4'd0) cur_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chan_mask = 4'($urandom);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!smp_valid && k < 100) begin
            tick();
            k++;
        end
    endtask

    task automatic push_pass(input logic [3:0] m);
        for (int c = 0; c < 4; c++)
            if (m[c]) exp_q.push_back({2'(c), w[c]});
    endtask

    function automatic int low_ch(input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) return i;
        return 0;
    endfunction

    task automatic rand_w();
        for (int i = 0; i < 4; i++) w[i] = DW'($urandom);
    endtask

    initial begin
        int k, n, d0;
        logic [3:0] m;
        logic [DW-1:0] hd;
        logic [1:0] hc, hs;
        for (int i = 0; i < 4; i++) w[i] = DW'(i + 1);

        #12;
        check("rst_s", 32'(s), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(smp_valid), 32'd0);
        check("rst_data", 32'(smp_data), 32'd0);
        check("rst_ch", 32'(smp_ch), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifndef SCAN_CONT_EN
        // single passes: directed masks first, then random masks, data and back-pressure
        for (int it = 0; it < 8; it++) begin
            if (it < 2) begin
                for (int i = 0; i < 4; i++) w[i] = DW'(i + 1);
                m = (it == 0) ? 4'b1111 : 4'b1010;
                smp_ready = 1'b1;
            end else begin
                rand_w();
                m = 4'($urandom_range(1, 15));
                smp_ready = 1'($urandom);
            end
            d0 = done_seen;
            push_pass(m);
            do_start(m);
            wait_valid(k);
            check("first_latency", 32'(k), 32'(DWELL));
            n = 0;
            while (busy && n < 400) begin
                if (it >= 2) smp_ready = 1'($urandom);
                tick();
                n++;
            end
            tick();
            check("pass_end_busy", 32'(busy), 32'd0);
            check("pass_done_count", 32'(done_seen - d0), 32'd1);
            check("pass_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // back-pressure for 10 cycles in HOLD
        rand_w();
        smp_ready = 1'b0;
        d0 = done_seen;
        push_pass(4'b1111);
        do_start(4'b1111);
        wait_valid(k);
        hd = smp_data; hc = smp_ch; hs = s;
        repeat (10) tick();
        check("stall_valid", 32'(smp_valid), 32'd1);
        check("stall_data", 32'({hc, hs, hd}), 32'({smp_ch, s, smp_data}));
        smp_ready = 1'b1;
        tick();
        wait_valid(k);
        check("post_stall_latency", 32'(k), 32'(DWELL));
        n = 0;
        while (busy && n < 400) begin tick(); n++; end
        tick();
        check("stall_done_count", 32'(done_seen - d0), 32'd1);
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        // stop in the second SETTLE cycle
        rand_w();
        smp_ready = 1'b1;
        d0 = done_seen;
        do_start(4'($urandom_range(1, 15)));
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_valid", 32'(smp_valid), 32'd0);
        repeat (6) tick();
        check("stop_no_done", 32'(done_seen - d0), 32'd0);
        do_start(4'd0);
        check("zero_mask_busy", 32'(busy), 32'd0);
        tick();
        check("zero_mask_busy2", 32'(busy), 32'd0);

        // stop coinciding with a handshake in HOLD
        smp_ready = 1'b0;
        d0 = done_seen;
        do_start(4'b1111);
        wait_valid(k);
        exp_q.push_back({2'd0, w[0]});
        smp_ready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_hs_busy", 32'(busy), 32'd0);
        check("stop_hs_valid", 32'(smp_valid), 32'd0);
        tick();
        check("stop_hs_no_done", 32'(done_seen - d0), 32'd0);
        check("stop_hs_queue", 32'(exp_q.size()), 32'd0);

        // asynchronous reset while holding a sample
        rand_w();
        smp_ready = 1'b0;
        do_start(4'b1110);
        wait_valid(k);
        #1 rst_n = 1'b0;
        #1;
        check("arst_outputs", 32'({s, busy, smp_valid, smp_data, smp_ch, done}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        m = 4'($urandom_range(1, 15));
        exp_q.push_back({2'(low_ch(m)), w[low_ch(m)]});
        do_start(m);
        wait_valid(k);
        check("restart_latency", 32'(k), 32'(DWELL));
        check("restart_lowest", 32'(s), 32'(low_ch(m)));
        smp_ready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("restart_stop_busy", 32'(busy), 32'd0);

`ifdef SCAN_CONT_EN
        // continuous scan of a single channel
        rand_w();
        smp_ready = 1'b1;
        d0 = done_seen;
        exp_q.push_back({2'd0, w[0]});
        do_start(4'b0001);
        wait_valid(k);
        check("cont_first_latency", 32'(k), 32'(DWELL));
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'd0, w[0]});
            tick();
            k = 1;
            while (!smp_valid && k < 50) begin tick(); k++; end
            check("cont_period", 32'(k), 32'(DWELL + 1));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cont_stop_busy", 32'(busy), 32'd0);
        tick();
        check("cont_done_count", 32'(done_seen - d0), 32'd4);
        check("cont_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
